// File: rtl/ipsxe_floating_point_pkg.sv
// Shared floating-point definitions: rounding-mode codes and exponent-format helpers.
package ipsxe_floating_point_pkg;

  typedef enum logic [2:0] {
    RM_RNE = 3'd0,
    RM_RTZ = 3'd1,
    RM_RDN = 3'd2,
    RM_RUP = 3'd3,
    RM_RMM = 3'd4
  } rm_e;

  function automatic int unsigned fp_bias(input int unsigned ew);
    return (32'd1 << (ew - 32'd1)) - 32'd1;
  endfunction

  function automatic int unsigned fp_max_e(input int unsigned ew);
    return (32'd1 << ew) - 32'd2;
  endfunction

endpackage

// File: rtl/ipsxe_floating_point_lzc_v1_1.sv
// Combinational leading-zero counter; an all-zero word returns WIDTH.
module ipsxe_floating_point_lzc_v1_1 #(
  parameter int unsigned WIDTH     = 49,
  parameter int unsigned CNT_WIDTH = 6
) (
  input  logic [WIDTH-1:0]     i_data,
  output logic [CNT_WIDTH-1:0] o_cnt_c
);

  // Scanning upward lets the highest set bit win.
  always_comb begin
    o_cnt_c = CNT_WIDTH'(WIDTH);
    for (int i = 0; i < int'(WIDTH); i++) begin
      if (i_data[i]) o_cnt_c = CNT_WIDTH'(int'(WIDTH) - 1 - i);
    end
  end

endmodule

// File: rtl/ipsxe_floating_point_round_rm_v1_1.sv
// Three-stage normalise/round/pack back end for the FMA sum word, with
// per-transaction rounding mode, lock-step valid/ready pipeline and flags.
module ipsxe_floating_point_round_rm_v1_1
  import ipsxe_floating_point_pkg::*;
#(
  parameter int unsigned EXP_WIDTH = 8,
  parameter int unsigned MAN_WIDTH = 23,
  parameter int unsigned LZC_WIDTH = 6,
  parameter int unsigned W_USER    = 1
) (
  input  logic                                       i_clk,
  input  logic                                       i_rst,
  input  logic                                       i_aclken,
  input  logic                                       i_valid,
  output logic                                       o_ready,
  input  logic [(2*(MAN_WIDTH+1)+1)+EXP_WIDTH+1:0]   i_add_out,
  input  logic [2:0]                                 i_rm,
  input  logic [W_USER-1:0]                          i_user,
  output logic                                       o_valid,
  input  logic                                       i_ready,
  output logic [EXP_WIDTH+MAN_WIDTH:0]               o_rounded_float,
  output logic [W_USER-1:0]                          o_user,
  output logic                                       o_overflow,
  output logic                                       o_underflow,
  output logic                                       o_inexact
);

  localparam int unsigned MW2 = 2*(MAN_WIDTH+1)+1;
  localparam int unsigned EW2 = EXP_WIDTH+2;
  localparam int unsigned RW  = EW2+MAN_WIDTH;
  localparam int unsigned OW  = 1+EXP_WIDTH+MAN_WIDTH;
  localparam int unsigned LW1 = LZC_WIDTH+1;
  localparam logic [EW2-1:0]        BIAS_V  = EW2'(fp_bias(EXP_WIDTH));
  localparam logic signed [EW2-1:0] MAX_E_S = EW2'(fp_max_e(EXP_WIDTH));
  localparam logic signed [EW2-1:0] ONE_S   = EW2'(1);
  localparam logic [EXP_WIDTH-1:0]  MAX_E_F = EXP_WIDTH'(fp_max_e(EXP_WIDTH));

  logic w_adv;
  assign w_adv   = i_aclken & (~o_valid | i_ready);
  assign o_ready = w_adv;

  // S1: split input word and count leading zeros
  logic                 w_sign0;
  logic [EXP_WIDTH:0]   w_exp0;
  logic [MW2-1:0]       w_man0;
  logic [LZC_WIDTH-1:0] w_lz0;
  assign {w_sign0, w_exp0, w_man0} = i_add_out;

  ipsxe_floating_point_lzc_v1_1 #(.WIDTH(MW2), .CNT_WIDTH(LZC_WIDTH)) u_lzc (
    .i_data  (w_man0),
    .o_cnt_c (w_lz0)
  );

  logic                 r_v1, r_sign1;
  logic [EXP_WIDTH:0]   r_exp1;
  logic [MW2-1:0]       r_man1;
  logic [LZC_WIDTH-1:0] r_lz1;
  logic [2:0]           r_rm1;
  logic [W_USER-1:0]    r_user1;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_v1 <= 1'b0; r_sign1 <= 1'b0; r_exp1 <= '0; r_man1 <= '0;
      r_lz1 <= '0; r_rm1 <= '0; r_user1 <= '0;
    end else if (w_adv) begin
      r_v1 <= i_valid; r_sign1 <= w_sign0; r_exp1 <= w_exp0; r_man1 <= w_man0;
      r_lz1 <= w_lz0; r_rm1 <= i_rm; r_user1 <= i_user;
    end
  end

  // S2: shift out the hidden one, extract G/S, compute the biased exponent
  logic [LW1-1:0] w_shamt;
  logic [MW2-1:0] w_norm;
  logic [EW2-1:0] w_e1;
  assign w_shamt = {1'b0, r_lz1} + LW1'(1);
  assign w_norm  = r_man1 << w_shamt;
  assign w_e1    = EW2'(r_exp1) + EW2'(2) - EW2'(r_lz1) - BIAS_V;

  logic                 r_v2, r_sign2, r_g2, r_s2, r_zero2;
  logic [EW2-1:0]       r_e2;
  logic [MAN_WIDTH-1:0] r_frac2;
  logic [2:0]           r_rm2;
  logic [W_USER-1:0]    r_user2;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_v2 <= 1'b0; r_sign2 <= 1'b0; r_g2 <= 1'b0; r_s2 <= 1'b0; r_zero2 <= 1'b0;
      r_e2 <= '0; r_frac2 <= '0; r_rm2 <= '0; r_user2 <= '0;
    end else if (w_adv) begin
      r_v2    <= r_v1;
      r_sign2 <= r_sign1;
      r_g2    <= w_norm[MW2-1-MAN_WIDTH];
      r_s2    <= |w_norm[MW2-2-MAN_WIDTH:0];
      r_zero2 <= (r_man1 == '0);
      r_e2    <= w_e1;
      r_frac2 <= w_norm[MW2-1 -: MAN_WIDTH];
      r_rm2   <= r_rm1;
      r_user2 <= r_user1;
    end
  end

  // S3: increment decision and whether overflow saturates to infinity
  logic w_inc, w_inf;
  always_comb begin
    w_inc = 1'b0;
    w_inf = 1'b1;
    case (r_rm2)
      RM_RTZ:  begin w_inc = 1'b0;                     w_inf = 1'b0;     end
      RM_RDN:  begin w_inc = r_sign2 & (r_g2 | r_s2);  w_inf = r_sign2;  end
      RM_RUP:  begin w_inc = ~r_sign2 & (r_g2 | r_s2); w_inf = ~r_sign2; end
      RM_RMM:  begin w_inc = r_g2;                     w_inf = 1'b1;     end
      default: begin w_inc = r_g2 & (r_s2 | r_frac2[0]); w_inf = 1'b1;   end
    endcase
  end

  logic [RW-1:0]         w_sum;
  logic signed [EW2-1:0] w_re;
  logic                  w_ovf, w_unf, w_inx;
  logic [OW-1:0]         w_res;
  assign w_sum = {r_e2, r_frac2} + RW'(w_inc);
  assign w_re  = w_sum[RW-1 -: EW2];
  assign w_ovf = ~r_zero2 & (w_re > MAX_E_S);
  assign w_unf = ~r_zero2 & (w_re < ONE_S);
  assign w_inx = ~r_zero2 & (r_g2 | r_s2 | w_ovf | w_unf);

  always_comb begin
    w_res = {r_sign2, w_re[EXP_WIDTH-1:0], w_sum[MAN_WIDTH-1:0]};
    if (r_zero2 || w_unf)
      w_res = {r_sign2, {(OW-1){1'b0}}};
    else if (w_ovf)
      w_res = w_inf ? {r_sign2, {EXP_WIDTH{1'b1}}, {MAN_WIDTH{1'b0}}}
                    : {r_sign2, MAX_E_F, {MAN_WIDTH{1'b1}}};
  end

  logic              r_v3, r_ovf3, r_unf3, r_inx3;
  logic [OW-1:0]     r_res3;
  logic [W_USER-1:0] r_user3;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_v3 <= 1'b0; r_ovf3 <= 1'b0; r_unf3 <= 1'b0; r_inx3 <= 1'b0;
      r_res3 <= '0; r_user3 <= '0;
    end else if (w_adv) begin
      r_v3 <= r_v2; r_ovf3 <= w_ovf; r_unf3 <= w_unf; r_inx3 <= w_inx;
      r_res3 <= w_res; r_user3 <= r_user2;
    end
  end

  assign o_valid         = r_v3;
  assign o_rounded_float = r_res3;
  assign o_user          = r_user3;
  assign o_overflow      = r_ovf3;
  assign o_underflow     = r_unf3;
  assign o_inexact       = r_inx3;

endmodule

// File: tb/tb_ipsxe_floating_point_round_rm_v1_1.sv
// Randomised and directed bench for the rounding back end, scored against an
// arithmetic reference model of the rounding rules.
module tb_ipsxe_floating_point_round_rm_v1_1;

  localparam int unsigned WU = 8;

  logic          i_clk = 1'b0;
  logic          i_rst, i_aclken, i_valid, i_ready;
  logic          o_ready, o_valid, o_overflow, o_underflow, o_inexact;
  logic [58:0]   i_add_out;
  logic [2:0]    i_rm;
  logic [WU-1:0] i_user, o_user;
  logic [31:0]   o_rounded_float;

  int n_chk = 0, n_fail = 0, n_out = 0;
  logic [WU-1:0] user_cnt = '0;
  logic [42:0]   exp_q[$];
  logic [42:0]   mon_exp, held_val;
  logic          held = 1'b0;

  always #5 i_clk = ~i_clk;

  ipsxe_floating_point_round_rm_v1_1 #(.EXP_WIDTH(8), .MAN_WIDTH(23), .LZC_WIDTH(6), .W_USER(WU)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_aclken(i_aclken), .i_valid(i_valid), .o_ready(o_ready),
    .i_add_out(i_add_out), .i_rm(i_rm), .i_user(i_user), .o_valid(o_valid), .i_ready(i_ready),
    .o_rounded_float(o_rounded_float), .o_user(o_user), .o_overflow(o_overflow),
    .o_underflow(o_underflow), .o_inexact(o_inexact)
  );

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, expv);
    end
  endtask

  // Returns {overflow, underflow, inexact, float32}, reasoning on the value's remainder.
  function automatic logic [34:0] ref_round(input logic s, input logic [8:0] ex,
                                            input logic [48:0] m, input logic [2:0] rm);
    int p, e, k;
    longint unsigned rem, low, half, frac;
    bit exact, tie, above, up, ovf, unf, inf;
    logic [31:0] f;
    if (m == 0) return {3'b000, s, 31'd0};
    p = 0;
    for (int i = 0; i < 49; i++) if (m[i]) p = i;
    rem = 64'(m) - (64'd1 << p);
    tie = 0; above = 0;
    if (p >= 23) begin
      k = p - 23;
      frac = rem >> k;
      low = rem & ((64'd1 << k) - 64'd1);
      exact = (low == 0);
      if (k > 0) begin
        half = 64'd1 << (k - 1);
        tie = (low == half);
        above = (low > half);
      end
    end else begin
      frac = rem << (23 - p);
      exact = 1;
    end
    case (rm)
      3'd1: up = 0;
      3'd2: up = s && !exact;
      3'd3: up = !s && !exact;
      3'd4: up = above || tie;
      default: up = above || (tie && frac[0]);
    endcase
    e = int'(ex) + 2 - (48 - p) - 127;
    frac = frac + 64'(up);
    if (frac == (64'd1 << 23)) begin frac = 0; e = e + 1; end
    ovf = (e > 254);
    unf = (e < 1);
    inf = (rm == 3'd1) ? 0 : (rm == 3'd2) ? s : (rm == 3'd3) ? !s : 1;
    if (ovf) f = inf ? {s, 8'hFF, 23'd0} : {s, 8'hFE, 23'h7FFFFF};
    else if (unf) f = {s, 31'd0};
    else f = {s, 8'(e), 23'(frac)};
    return {ovf, unf, !exact || ovf || unf, f};
  endfunction

  // Scoreboard: accept/consume decisions are made at the negedge before the edge that commits them.
  always @(negedge i_clk) begin
    chk("ready", o_ready, i_aclken & (~o_valid | i_ready));
    if (held && o_valid)
      chk("hold", {o_user, o_overflow, o_underflow, o_inexact, o_rounded_float}, held_val);
    if (!i_rst && i_aclken) begin
      if (o_valid && i_ready) begin
        if (exp_q.size() == 0) chk("unexpected_out", 64'(exp_q.size() == 0), 0);
        else begin
          mon_exp = exp_q.pop_front();
          chk("result", {o_user, o_overflow, o_underflow, o_inexact, o_rounded_float}, mon_exp);
          n_out++;
        end
      end
      if (i_valid && o_ready)
        exp_q.push_back({i_user, ref_round(i_add_out[58], i_add_out[57:49], i_add_out[48:0], i_rm)});
    end
    held = o_valid && !(i_ready && i_aclken) && !i_rst;
    held_val = {o_user, o_overflow, o_underflow, o_inexact, o_rounded_float};
  end

  task automatic put(input logic s, input logic [8:0] e, input logic [48:0] m, input logic [2:0] rm);
    i_add_out = {s, e, m};
    i_rm = rm;
    i_user = user_cnt;
    user_cnt = user_cnt + 1'b1;
  endtask

  task automatic rand_word();
    int p, et;
    logic [63:0] r;
    logic [48:0] m;
    logic [8:0] e;
    p = int'($urandom_range(0, 48));
    r = {$urandom, $urandom};
    m = (49'(r) & ((49'd1 << p) - 49'd1)) | (49'd1 << p);
    case ($urandom_range(0, 7))
      0: m = '0;
      1: if (p >= 23) m = m & ~((49'd1 << (p - 23)) - 49'd1);
      2: if (p >= 24) m = (m & ~((49'd1 << (p - 23)) - 49'd1)) | (49'd1 << (p - 24));
      default: ;
    endcase
    et = int'($urandom_range(0, 259)) - 2;
    e = 9'(et - 2 + (48 - p) + 127);
    if ($urandom_range(0, 7) == 0) e = 9'($urandom);
    put(1'($urandom_range(0, 1)), e, m, 3'($urandom_range(0, 7)));
  endtask

  // Single word through an empty pipeline: checks latency and the exact packed result.
  task automatic dir(input string tag, input logic s, input logic [8:0] e, input logic [48:0] m,
                     input logic [2:0] rm, input logic [31:0] f_exp, input logic [2:0] fl_exp);
    int lat;
    put(s, e, m, rm);
    i_valid = 1'b1;
    @(posedge i_clk); #1;
    i_valid = 1'b0;
    lat = 1;
    while (!o_valid && lat < 20) begin @(posedge i_clk); #1; lat++; end
    chk($sformatf("%s_lat", tag), 64'(lat), 3);
    chk(tag, {o_overflow, o_underflow, o_inexact, o_rounded_float}, {fl_exp, f_exp});
    @(posedge i_clk); #1;
  endtask

  logic [31:0] tie_f [5] = '{32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h3F800001, 32'h3F800001};
  logic [31:0] ovf_f [5] = '{32'h7F800000, 32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F800000, 32'h7F800000};
  logic [31:0] cy_f  [5] = '{32'h7F800000, 32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F800000, 32'h7F800000};
  logic [2:0]  cy_fl [5] = '{3'b101, 3'b001, 3'b001, 3'b101, 3'b101};

  initial begin
    logic [48:0] m_one, m_tie, m_cy;
    int n0, sent, cyc;
    logic acc;
    m_one = 49'd1 << 46;
    m_tie = m_one | (49'd1 << 22);
    m_cy  = ((49'd1 << 47) - 49'd1) & ~((49'd1 << 22) - 49'd1);
    i_rst = 1'b1; i_aclken = 1'b1; i_valid = 1'b0; i_ready = 1'b1;
    i_add_out = '0; i_rm = '0; i_user = '0;
    repeat (2) @(posedge i_clk);
    #1;
    chk("rst_valid", o_valid, 0);
    chk("rst_out", {o_user, o_overflow, o_underflow, o_inexact, o_rounded_float}, 0);
    i_rst = 1'b0;
    repeat (2) @(posedge i_clk);
    #1;

    for (int rm = 0; rm < 5; rm++) begin
      dir($sformatf("one_rm%0d", rm), 1'b0, 9'd254, m_one, 3'(rm), 32'h3F800000, 3'b000);
      dir($sformatf("tie_rm%0d", rm), 1'b0, 9'd254, m_tie, 3'(rm), tie_f[rm], 3'b001);
      dir($sformatf("ovf_rm%0d", rm), 1'b0, 9'd382, m_one, 3'(rm), ovf_f[rm], 3'b101);
      dir($sformatf("carry_rm%0d", rm), 1'b0, 9'd381, m_cy, 3'(rm), cy_f[rm], cy_fl[rm]);
      dir($sformatf("unf_rm%0d", rm), 1'b1, 9'd127, m_one, 3'(rm), 32'h80000000, 3'b011);
    end
    dir("tie_rm6_as_rne", 1'b0, 9'd254, m_tie, 3'd6, 32'h3F800000, 3'b001);
    dir("ovf_neg_rup", 1'b1, 9'd382, m_one, 3'd3, 32'hFF7FFFFF, 3'b101);
    dir("ovf_neg_rdn", 1'b1, 9'd382, m_one, 3'd2, 32'hFF800000, 3'b101);
    dir("zero_pos", 1'b0, 9'd300, 49'd0, 3'd3, 32'h00000000, 3'b000);

    // Ten-word stream with a four-cycle downstream stall in the middle
    n0 = n_out; sent = 0; cyc = 0;
    rand_word();
    while (sent < 10 && cyc < 100) begin
      i_valid = 1'b1;
      i_ready = !(cyc >= 4 && cyc < 8);
      @(negedge i_clk); acc = o_ready;
      @(posedge i_clk); #1;
      cyc++;
      if (acc) begin sent++; if (sent < 10) rand_word(); end
    end
    i_valid = 1'b0; i_ready = 1'b1;
    cyc = 0;
    while (exp_q.size() != 0 && cyc < 50) begin @(posedge i_clk); #1; cyc++; end
    chk("bp_count", 64'(n_out - n0), 10);

    // Random traffic with random backpressure and clock-enable gaps
    for (int i = 0; i < 3000; i++) begin
      rand_word();
      i_valid  = ($urandom_range(0, 3) != 0);
      i_ready  = ($urandom_range(0, 3) != 0);
      i_aclken = ($urandom_range(0, 15) != 0);
      @(posedge i_clk); #1;
    end
    i_valid = 1'b0; i_ready = 1'b1; i_aclken = 1'b1;
    cyc = 0;
    while (exp_q.size() != 0 && cyc < 50) begin @(posedge i_clk); #1; cyc++; end
    chk("drain", 64'(exp_q.size()), 0);

    // Reset with three words in flight, clock enable low
    for (int i = 0; i < 3; i++) begin
      rand_word(); i_valid = 1'b1;
      @(posedge i_clk); #1;
    end
    i_valid = 1'b0; i_rst = 1'b1; i_aclken = 1'b0;
    @(posedge i_clk); #1;
    chk("rst_flush_valid", o_valid, 0);
    chk("rst_flush_out", {o_user, o_overflow, o_underflow, o_inexact, o_rounded_float}, 0);
    exp_q.delete();
    i_rst = 1'b0; i_aclken = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge i_clk); #1;
      chk("no_stale", o_valid, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
